// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, ROM addressing and IF/ID register with stall, branch redirect and fetch counter.
// Optional build macro IFETCH_HALT_EN: a fetched zero word halts fetch until reset.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'h0000_0004,
    parameter logic [31:0] PC_WRAP  = 32'h0000_0100,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic [31:0]      instr,
    output logic [31:0]      instr_pc,
    output logic             instr_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count,
    output logic             halted
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t           state_r;
    logic [31:0]      pc_r;
    logic [31:0]      instr_r;
    logic [31:0]      instr_pc_r;
    logic             instr_valid_r;
    logic             misalign_err_r;
    logic [CNT_W-1:0] fetch_count_r;

    logic [31:0]      pc_inc_s;
    logic [31:0]      seq_pc_s;
    logic [CNT_W-1:0] count_next_s;
    logic [31:0]      redirect_pc_s;

    // Sequential next PC with wrap, saturating counter increment and word-aligned redirect target
    always_comb begin
        pc_inc_s      = pc_r + PC_STEP;
        seq_pc_s      = pc_inc_s;
        count_next_s  = fetch_count_r;
        redirect_pc_s = {branch_target[31:2], 2'b00};
        if (pc_inc_s == PC_WRAP) begin
            seq_pc_s = RESET_PC;
        end else begin
            seq_pc_s = pc_inc_s;
        end
        if (&fetch_count_r) begin
            count_next_s = fetch_count_r;
        end else begin
            count_next_s = fetch_count_r + CNT_W'(1);
        end
    end

`ifdef IFETCH_HALT_EN
    logic halted_r;
`endif

    // Fetch FSM and all IF/ID state; branch beats stall, stall beats sequential load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= S_BOOT;
            pc_r           <= RESET_PC;
            instr_r        <= 32'h0000_0000;
            instr_pc_r     <= 32'h0000_0000;
            instr_valid_r  <= 1'b0;
            misalign_err_r <= 1'b0;
            fetch_count_r  <= '0;
`ifdef IFETCH_HALT_EN
            halted_r       <= 1'b0;
`endif
        end else begin
            misalign_err_r <= 1'b0;
            case (state_r)
                S_BOOT: begin
                    state_r <= S_RUN;
                end
                S_RUN: begin
                    if (branch_taken) begin
                        // Wrong-path word in IF/ID is dropped; instr/instr_pc keep their last value
                        pc_r           <= redirect_pc_s;
                        instr_valid_r  <= 1'b0;
                        misalign_err_r <= |branch_target[1:0];
                    end else if (stall) begin
                        pc_r          <= pc_r;
                        instr_valid_r <= instr_valid_r;
                    end
`ifdef IFETCH_HALT_EN
                    else if (imem_data == 32'h0000_0000) begin
                        state_r       <= S_HALT;
                        instr_valid_r <= 1'b0;
                        halted_r      <= 1'b1;
                    end
`endif
                    else begin
                        instr_r       <= imem_data;
                        instr_pc_r    <= pc_r;
                        instr_valid_r <= 1'b1;
                        fetch_count_r <= count_next_s;
                        pc_r          <= seq_pc_s;
                    end
                end
`ifdef IFETCH_HALT_EN
                S_HALT: begin
                    state_r <= S_HALT;
                end
`endif
                default: begin
                    // Unreachable encoding: restart cleanly from boot without presenting a word
                    state_r       <= S_BOOT;
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr    = pc_r;
    assign instr        = instr_r;
    assign instr_pc     = instr_pc_r;
    assign instr_valid  = instr_valid_r;
    assign misalign_err = misalign_err_r;
    assign fetch_count  = fetch_count_r;
`ifdef IFETCH_HALT_EN
    assign halted       = halted_r;
`else
    assign halted       = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit: one task per scenario.
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall, branch_taken;
    logic [31:0] branch_target, imem_addr, imem_data, instr, instr_pc;
    logic        instr_valid, misalign_err, halted;
    logic [15:0] fetch_count;

    logic        reset2, stall2, branch_taken2;
    logic [31:0] branch_target2, imem_addr2, imem_data2, instr2, instr_pc2;
    logic        instr_valid2, misalign_err2, halted2;
    logic [3:0]  fetch_count2;

    int n_run  = 0;
    int n_fail = 0;

    assign imem_data  = (imem_addr  < 32'h0000_0100) ? (32'hE000_0000 | imem_addr)  : 32'h0000_0000;
    assign imem_data2 = (imem_addr2 < 32'h0000_0100) ? (32'hE000_0000 | imem_addr2) : 32'h0000_0000;

    instruction_fetch_unit dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .misalign_err(misalign_err), .fetch_count(fetch_count), .halted(halted)
    );

    instruction_fetch_unit #(.PC_WRAP(32'h0000_0200), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset2), .imem_addr(imem_addr2), .imem_data(imem_data2),
        .stall(stall2), .branch_taken(branch_taken2), .branch_target(branch_target2),
        .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2),
        .misalign_err(misalign_err2), .fetch_count(fetch_count2), .halted(halted2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        tick(); tick();
        n_run++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h exp %h", imem_addr, 32'h0); end
        n_run++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h exp %h", instr, 32'h0); end
        n_run++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL rst_instr_pc got %h exp %h", instr_pc, 32'h0); end
        n_run++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
        n_run++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL rst_misalign got %b exp 0", misalign_err); end
        n_run++; if (fetch_count !== 16'h0) begin n_fail++; $display("FAIL rst_count got %h exp 0000", fetch_count); end
        n_run++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted got %b exp 0", halted); end
        // Branch during the boot edge must be ignored
        reset = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0040;
        tick();
        n_run++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL boot_branch_pc got %h exp %h", imem_addr, 32'h0); end
        n_run++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid got %b exp 0", instr_valid); end
        branch_taken = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_w;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_w = 32'hE000_0000 | (i * 4);
            n_run++; if (instr !== exp_w) begin n_fail++; $display("FAIL seq_instr%0d got %h exp %h", i, instr, exp_w); end
            n_run++; if (instr_pc !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_pc%0d got %h exp %h", i, instr_pc, 32'(i * 4)); end
            n_run++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d got %b exp 1", i, instr_valid); end
        end
        n_run++; if (fetch_count !== 16'd3) begin n_fail++; $display("FAIL seq_count got %0d exp 3", fetch_count); end
    endtask

    task automatic test_stall();
        reset = 1'b1; tick(); reset = 1'b0;
        tick(); tick(); tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_run++; if (instr !== 32'hE000_0004) begin n_fail++; $display("FAIL stall_instr%0d got %h exp %h", i, instr, 32'hE000_0004); end
            n_run++; if (instr_pc !== 32'h4) begin n_fail++; $display("FAIL stall_ipc%0d got %h exp %h", i, instr_pc, 32'h4); end
            n_run++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_pc%0d got %h exp %h", i, imem_addr, 32'h8); end
            n_run++; if (fetch_count !== 16'd2) begin n_fail++; $display("FAIL stall_count%0d got %0d exp 2", i, fetch_count); end
        end
        stall = 1'b0;
        tick();
        n_run++; if (instr !== 32'hE000_0008) begin n_fail++; $display("FAIL stall_rel_instr got %h exp %h", instr, 32'hE000_0008); end
        n_run++; if (fetch_count !== 16'd3) begin n_fail++; $display("FAIL stall_rel_count got %0d exp 3", fetch_count); end
    endtask

    task automatic test_branch_over_stall();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0040;
        tick();
        stall = 1'b0; branch_taken = 1'b0;
        n_run++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid got %b exp 0", instr_valid); end
        n_run++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL br_pc got %h exp %h", imem_addr, 32'h40); end
        n_run++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL br_misalign got %b exp 0", misalign_err); end
        n_run++; if (instr_pc !== 32'h8) begin n_fail++; $display("FAIL br_hold_ipc got %h exp %h", instr_pc, 32'h8); end
        tick();
        n_run++; if (instr !== 32'hE000_0040) begin n_fail++; $display("FAIL br_instr got %h exp %h", instr, 32'hE000_0040); end
        n_run++; if (instr_pc !== 32'h40) begin n_fail++; $display("FAIL br_ipc got %h exp %h", instr_pc, 32'h40); end
        n_run++; if (fetch_count !== 16'd4) begin n_fail++; $display("FAIL br_count got %0d exp 4", fetch_count); end
    endtask

    task automatic test_misalign();
        branch_taken = 1'b1; branch_target = 32'h0000_004E;
        tick();
        branch_taken = 1'b0;
        n_run++; if (imem_addr !== 32'h4C) begin n_fail++; $display("FAIL mis_pc got %h exp %h", imem_addr, 32'h4C); end
        n_run++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_err got %b exp 1", misalign_err); end
        tick();
        n_run++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_err_clr got %b exp 0", misalign_err); end
        n_run++; if (instr !== 32'hE000_004C) begin n_fail++; $display("FAIL mis_instr got %h exp %h", instr, 32'hE000_004C); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hF8; exp_pc[1] = 32'hFC; exp_pc[2] = 32'h00;
        branch_taken = 1'b1; branch_target = 32'h0000_00F8;
        tick();
        branch_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_run++; if (instr_pc !== exp_pc[i]) begin n_fail++; $display("FAIL wrap_ipc%0d got %h exp %h", i, instr_pc, exp_pc[i]); end
        end
        n_run++; if (instr !== 32'hE000_0000) begin n_fail++; $display("FAIL wrap_instr got %h exp %h", instr, 32'hE000_0000); end
        n_run++; if (fetch_count !== 16'd8) begin n_fail++; $display("FAIL wrap_count got %0d exp 8", fetch_count); end
    endtask

    task automatic test_back_to_back();
        branch_taken = 1'b1; branch_target = 32'h0000_0010;
        tick();
        branch_target = 32'h0000_0020;
        tick();
        branch_taken = 1'b0;
        n_run++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL b2b_pc got %h exp %h", imem_addr, 32'h20); end
        n_run++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid got %b exp 0", instr_valid); end
        tick();
        n_run++; if (instr !== 32'hE000_0020) begin n_fail++; $display("FAIL b2b_instr got %h exp %h", instr, 32'hE000_0020); end
        n_run++; if (fetch_count !== 16'd9) begin n_fail++; $display("FAIL b2b_count got %0d exp 9", fetch_count); end
    endtask

    task automatic test_async_reset();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0080;
        #2 reset = 1'b1;
        #1;
        n_run++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL arst_pc got %h exp %h", imem_addr, 32'h0); end
        n_run++; if (instr !== 32'h0) begin n_fail++; $display("FAIL arst_instr got %h exp %h", instr, 32'h0); end
        n_run++; if (fetch_count !== 16'h0) begin n_fail++; $display("FAIL arst_count got %h exp 0000", fetch_count); end
        tick();
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        tick();
        n_run++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL arst_boot_valid got %b exp 0", instr_valid); end
        tick();
        n_run++; if (instr !== 32'hE000_0000) begin n_fail++; $display("FAIL arst_first got %h exp %h", instr, 32'hE000_0000); end
        n_run++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL arst_first_pc got %h exp %h", instr_pc, 32'h0); end
    endtask

    task automatic test_saturation();
        reset2 = 1'b0;
        tick();
        repeat (14) tick();
        n_run++; if (fetch_count2 !== 4'hE) begin n_fail++; $display("FAIL sat_pre got %h exp E", fetch_count2); end
        repeat (3) tick();
        n_run++; if (fetch_count2 !== 4'hF) begin n_fail++; $display("FAIL sat_hold got %h exp F", fetch_count2); end
        n_run++; if (instr_pc2 !== 32'h40) begin n_fail++; $display("FAIL sat_ipc got %h exp %h", instr_pc2, 32'h40); end
    endtask

    task automatic test_halt();
        branch_taken2 = 1'b1; branch_target2 = 32'h0000_00FC;
        tick();
        branch_taken2 = 1'b0;
        tick();
        n_run++; if (imem_addr2 !== 32'h100) begin n_fail++; $display("FAIL halt_pre_pc got %h exp %h", imem_addr2, 32'h100); end
        tick();
`ifdef IFETCH_HALT_EN
        n_run++; if (halted2 !== 1'b1) begin n_fail++; $display("FAIL halt_flag got %b exp 1", halted2); end
        n_run++; if (instr_valid2 !== 1'b0) begin n_fail++; $display("FAIL halt_valid got %b exp 0", instr_valid2); end
        n_run++; if (instr2 !== 32'hE000_00FC) begin n_fail++; $display("FAIL halt_instr got %h exp %h", instr2, 32'hE000_00FC); end
        branch_taken2 = 1'b1; branch_target2 = 32'h0000_0040; stall2 = 1'b1;
        tick();
        branch_taken2 = 1'b0; stall2 = 1'b0;
        tick();
        n_run++; if (imem_addr2 !== 32'h100) begin n_fail++; $display("FAIL halt_pc_hold got %h exp %h", imem_addr2, 32'h100); end
        n_run++; if (halted2 !== 1'b1) begin n_fail++; $display("FAIL halt_stay got %b exp 1", halted2); end
`else
        n_run++; if (halted2 !== 1'b0) begin n_fail++; $display("FAIL nohalt_flag got %b exp 0", halted2); end
        n_run++; if (instr_valid2 !== 1'b1) begin n_fail++; $display("FAIL nohalt_valid got %b exp 1", instr_valid2); end
        n_run++; if (instr2 !== 32'h0) begin n_fail++; $display("FAIL nohalt_instr got %h exp %h", instr2, 32'h0); end
        n_run++; if (instr_pc2 !== 32'h100) begin n_fail++; $display("FAIL nohalt_ipc got %h exp %h", instr_pc2, 32'h100); end
        n_run++; if (imem_addr2 !== 32'h104) begin n_fail++; $display("FAIL nohalt_pc got %h exp %h", imem_addr2, 32'h104); end
`endif
        reset2 = 1'b1;
        #1;
        n_run++; if (halted2 !== 1'b0) begin n_fail++; $display("FAIL halt_rst_flag got %b exp 0", halted2); end
        n_run++; if (imem_addr2 !== 32'h0) begin n_fail++; $display("FAIL halt_rst_pc got %h exp %h", imem_addr2, 32'h0); end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        reset2 = 1'b1; stall2 = 1'b0; branch_taken2 = 1'b0; branch_target2 = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch_over_stall();
        test_misalign();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
